// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands, streams the sum LSB first
// through a full adder, and assembles the parallel sum and final carry.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             sum_bit,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sum_bit_q, sum_bit_d;
    logic             sum_valid_q, sum_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             add_bit_s;
    logic             add_carry_s;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder slice on the current operand LSBs.
    always_comb begin
        add_bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        add_carry_s = maj3(a_sh_q[0], b_sh_q[0], c_q);
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_bit_d   = sum_bit_q;
        sum_valid_d = sum_valid_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE: begin
                sum_bit_d   = 1'b0;
                sum_valid_d = 1'b0;
                done_d      = 1'b0;
                if (start) begin
                    state_d     = S_ADD;
                    a_sh_d      = a;
                    b_sh_d      = b;
                    c_d         = 1'b0;
                    cnt_d       = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                sum_bit_d   = add_bit_s;
                sum_valid_d = 1'b1;
                c_d         = add_carry_s;
                a_sh_d      = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d       = {add_bit_s, sum_q[WIDTH-1:1]};
                cnt_d       = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                // The edge producing the MSB also publishes the final carry.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    carry_out_d = add_carry_s;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                done_d      = 1'b0;
                sum_valid_d = 1'b0;
                sum_bit_d   = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                sum_bit_d   = 1'b0;
                sum_valid_d = 1'b0;
                done_d      = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_bit_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_bit_q   <= sum_bit_d;
            sum_valid_q <= sum_valid_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sum_bit   = sum_bit_q;
    assign sum_valid = sum_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): vector table plus hand-written
// sequences for held start, mid-operation reset and IDLE hold.
module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       sum_bit;
    logic       sum_valid;
    logic [3:0] sum;
    logic       carry_out;
    logic       busy;
    logic       done;
    logic [3:0] ds_q;

    int nvec;
    int nerr;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    serial_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .sum_bit   (sum_bit),
        .sum_valid (sum_valid),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit shift register fed by sum_bit (first bit ends in q[3]).
    always_ff @(posedge clk) begin
        if (reset) ds_q <= 4'd0;
        else       ds_q <= {ds_q[2:0], sum_bit};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sum_bit"},   {31'd0, sum_bit},   32'd0);
        chk({tag, ".sum_valid"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, ".sum"},       {28'd0, sum},       32'd0);
        chk({tag, ".carry_out"}, {31'd0, carry_out}, 32'd0);
        chk({tag, ".busy"},      {31'd0, busy},      32'd0);
        chk({tag, ".done"},      {31'd0, done},      32'd0);
    endtask

    // Caller has set start/a/b at a negedge. Checks one full operation and
    // ends at the negedge of the IDLE cycle following DONE. Operands are
    // overwritten with new_a/new_b right after capture.
    task automatic check_op(input string tag, input logic [3:0] exp_sum, input logic exp_cout,
                            input logic hold, input logic [3:0] new_a, input logic [3:0] new_b);
        logic [3:0] exp_q;
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = new_a;
        b = new_b;
        chk({tag, ".add0_busy"},  {31'd0, busy},      32'd1);
        chk({tag, ".add0_valid"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, ".add0_sum"},   {28'd0, sum},       32'd0);
        chk({tag, ".add0_cout"},  {31'd0, carry_out}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("%s.valid%0d", tag, k), {31'd0, sum_valid}, 32'd1);
            chk($sformatf("%s.bit%0d", tag, k),   {31'd0, sum_bit},   {31'd0, exp_sum[k]});
            chk($sformatf("%s.done%0d", tag, k),  {31'd0, done},      (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s.busy%0d", tag, k),  {31'd0, busy},      32'd1);
        end
        chk({tag, ".sum"},  {28'd0, sum},       {28'd0, exp_sum});
        chk({tag, ".cout"}, {31'd0, carry_out}, {31'd0, exp_cout});
        @(negedge clk);
        exp_q = {exp_sum[0], exp_sum[1], exp_sum[2], exp_sum[3]};
        chk({tag, ".idle_busy"},  {31'd0, busy},      32'd0);
        chk({tag, ".idle_valid"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, ".idle_bit"},   {31'd0, sum_bit},   32'd0);
        chk({tag, ".idle_done"},  {31'd0, done},      32'd0);
        chk({tag, ".idle_sum"},   {28'd0, sum},       {28'd0, exp_sum});
        chk({tag, ".idle_cout"},  {31'd0, carry_out}, {31'd0, exp_cout});
        chk({tag, ".ds_q"},       {28'd0, ds_q},      {28'd0, exp_q});
    endtask

    initial begin
        vec_t vecs[6];
        nvec  = 0;
        nerr  = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  sum: 4'd8,  cout: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1,  sum: 4'd0,  cout: 1'b1};
        vecs[2] = '{a: 4'd15, b: 4'd15, sum: 4'd14, cout: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  sum: 4'd0,  cout: 1'b0};
        vecs[4] = '{a: 4'd9,  b: 4'd6,  sum: 4'd15, cout: 1'b0};
        vecs[5] = '{a: 4'd10, b: 4'd11, sum: 4'd5,  cout: 1'b1};

        // Reset with start asserted: start must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset.busy", {31'd0, busy}, 32'd0);

        // Table vectors, back-to-back: each start is raised in the IDLE cycle after DONE.
        for (int i = 0; i < 6; i++) begin
            a     = vecs[i].a;
            b     = vecs[i].b;
            start = 1'b1;
            check_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, 1'b0, ~vecs[i].a, ~vecs[i].b);
        end

        // IDLE with start low holds the last result.
        repeat (3) @(negedge clk);
        chk("hold.busy", {31'd0, busy},      32'd0);
        chk("hold.sum",  {28'd0, sum},       32'd5);
        chk("hold.cout", {31'd0, carry_out}, 32'd1);
        chk("hold.done", {31'd0, done},      32'd0);

        // start held high with operands changed mid-operation.
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        check_op("held1", 4'd8, 1'b0, 1'b1, 4'd15, 4'd15);
        check_op("held2", 4'd14, 1'b1, 1'b0, 4'd1, 4'd2);

        // Reset during the second ADD cycle, with start asserted alongside.
        a     = 4'd9;
        b     = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst.busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("pre_rst.valid", {31'd0, sum_valid}, 32'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst");
        reset = 1'b0;
        a     = 4'd6;
        b     = 4'd7;
        check_op("after_rst", 4'd13, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 sum_bit  output  1  registered serial sum bit, LSB first; feeds the downstream 4-bit shift register bit_in.
REQ-008 sum_valid  output  1  registered; high while sum_bit carries a valid sum bit.
REQ-009 sum  output  WIDTH  parallel sum, assembled as bits are produced.
REQ-010 carry_out  output  1  final carry of the addition.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, ADD, DONE; encoding is free.
REQ-014 IDLE: start=1 at an edge SHALL load a, b into internal shift registers, clear carry, sum and carry_out, zero the bit counter, and go to ADD.
REQ-015 IDLE: start=0 SHALL hold state and all outputs; sum and carry_out keep the last result.
REQ-016 ADD, each edge: sum_bit <= a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0], b_sh[0], c); a_sh, b_sh shift right by one; sum <= {new bit, sum[WIDTH-1:1]}; counter increments; sum_valid <= 1.
REQ-017 After WIDTH edges in ADD, state SHALL go to DONE, with carry_out <= final carry on that same edge.
REQ-018 DONE cycle: done=1, sum_valid=1 (last bit, index WIDTH-1), sum and carry_out final.
REQ-019 Edge leaving DONE: state -> IDLE, done <= 0, sum_valid <= 0, sum_bit <= 0.
REQ-020 sum_bit SHALL be 0 whenever sum_valid is 0.
REQ-021 sum_valid SHALL be high for exactly WIDTH consecutive cycles per operation; bit k (k=0..WIDTH-1) appears in the k-th of them.
REQ-022 Latency: start edge to done cycle = WIDTH edges; IDLE-to-IDLE = WIDTH+2 cycles.
REQ-023 Result: {carry_out, sum} SHALL equal a + b (captured values), exact, WIDTH+1 bits.
REQ-024 start in ADD or DONE SHALL be ignored, with no queuing; a/b changes after capture SHALL not affect the result.
REQ-025 start asserted in the first IDLE cycle after DONE SHALL be accepted (back-to-back operation).
REQ-026 busy SHALL be high in ADD and DONE and low in IDLE.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE with sum_bit, sum_valid, sum, carry_out, busy, done, carry, counter and operand registers all 0, overriding any operation in progress.
REQ-028 start coincident with reset SHALL be ignored; the first start accepted is at the first edge with reset=0.

Verification (WIDTH=4)
REQ-029 a=3, b=5, start pulse -> sum_bit 0,0,0,1 over 4 sum_valid cycles; done in 4th; sum=8, carry_out=0.
REQ-030 a=15, b=1 -> stream 0,0,0,0; sum=0, carry_out=1; a=15, b=15 -> stream 0,1,1,1; sum=14, carry_out=1.
REQ-031 a=0, b=0 -> sum_valid still 4 cycles, all bits 0, done pulses, sum=0, carry_out=0.
REQ-032 start held high throughout, with a/b changed mid-operation -> first operands' result unaffected; next operation starts in the IDLE cycle after DONE; busy low for exactly that one cycle.
REQ-033 reset asserted during the 2nd ADD cycle -> next cycle all outputs 0, state IDLE; subsequent start with a=6, b=7 -> sum=13, carry_out=0.
REQ-034 sum_bit connected to the downstream shift register -> after the DONE-cycle edge, its q equals the sum bits in arrival order (q[3]=bit0 ... q[0]=bit3).
